matrix_result_serializer: RTL and testbench

MATRIX_RESULT_SERIALIZER -- requirements
Module: matrix_result_serializer

---
 rtl/matrix_pkg.sv | 26 ++
 rtl/matrix_vec_counter.sv | 35 +++
 rtl/matrix_result_serializer.sv | 164 ++++++++++++++++
 tb/tb_matrix_result_serializer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix result serializer slice.
// Holds the vector geometry, index width and FSM state encoding used by
// the serializer top and its helpers.
package matrix_pkg;

  // Number of result elements produced per constant-matrix multiply
  localparam int VEC_LEN = 3;

  // Width of the element index carried alongside each output element
  localparam int IDX_W = 2;

  // Index of the final element of a vector
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  // Serializer FSM: IDLE waits for a vector, SEND streams its elements
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Index of the element that follows the given one within a vector
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/matrix_vec_counter.sv
// Free-running vector counter for the serializer.
// Counts enabled cycles with an 8-bit (default) wrap-around and a
// synchronous active-low clear that dominates the enable.
module matrix_vec_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         clr_n_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: step by one on enable, natural wrap from all-ones to zero
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register with clear taking priority over counting
  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/matrix_result_serializer.sv
// Matrix result serializer.
// Accepts a three-element result vector from the constant-matrix multiplier
// in one cycle and streams it out one element per cycle with a valid/ready
// handshake. A new vector can be accepted on the same cycle the last element
// leaves, so back-to-back vectors stream without bubbles.
//
// Optional feature: define MATRIX_RESULT_ACC_EN to add the acc_clr input.
// With it, each captured vector is added element-wise into the held buffer
// (modulo 2^DATA_W) unless acc_clr requests a plain load, and the buffer
// persists across idle periods.
module matrix_result_serializer
  import matrix_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] c0,
  input  logic [DATA_W-1:0] c1,
  input  logic [DATA_W-1:0] c2,
`ifdef MATRIX_RESULT_ACC_EN
  input  logic              acc_clr,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic [7:0]        vec_count,
  output logic              busy
);

  state_e             state_q;
  state_e             state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_d;
  logic [DATA_W-1:0]  elem_q [VEC_LEN];
  logic [DATA_W-1:0]  elem_d [VEC_LEN];
  logic [DATA_W-1:0]  out_data_q;
  logic [DATA_W-1:0]  out_data_d;
  logic [DATA_W-1:0]  cap    [VEC_LEN];
  logic [DATA_W-1:0]  next_elem;
  logic               at_last;
  logic               accept;
  logic               advance;

  // True while the element currently presented is the final one of its vector
  assign at_last = (idx_q == LAST_IDX);

  // Handshake qualifiers shared by the FSM and the datapath
  assign accept  = in_valid && in_ready;
  assign advance = out_valid && out_ready && !at_last;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: stay in SEND across the last element when a new vector is waiting
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready && at_last) begin
          state_d = in_valid ? SEND : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, including the combinational in_ready that enables zero-bubble reload
  always_comb begin
    out_valid = (state_q == SEND);
    busy      = (state_q == SEND);
    out_last  = (state_q == SEND) && at_last;
    in_ready  = (state_q == IDLE) || ((state_q == SEND) && at_last && out_ready);
  end

  // Value written into each buffer slot when a vector is accepted
`ifdef MATRIX_RESULT_ACC_EN
  always_comb begin
    cap[0] = acc_clr ? c0 : elem_q[0] + c0;
    cap[1] = acc_clr ? c1 : elem_q[1] + c1;
    cap[2] = acc_clr ? c2 : elem_q[2] + c2;
  end
`else
  always_comb begin
    cap[0] = c0;
    cap[1] = c1;
    cap[2] = c2;
  end
`endif

  // Buffered element that will be presented after the current one
  always_comb begin
    case (next_idx(idx_q))
      2'd1:    next_elem = elem_q[1];
      2'd2:    next_elem = elem_q[2];
      default: next_elem = elem_q[0];
    endcase
  end

  // Datapath next-state: capture on accept, step index and output register on advance
  always_comb begin
    idx_d      = idx_q;
    out_data_d = out_data_q;
    for (int i = 0; i < VEC_LEN; i++) begin
      elem_d[i] = elem_q[i];
    end
    if (accept) begin
      idx_d      = '0;
      out_data_d = cap[0];
      for (int i = 0; i < VEC_LEN; i++) begin
        elem_d[i] = cap[i];
      end
    end else if (advance) begin
      idx_d      = next_idx(idx_q);
      out_data_d = next_elem;
    end
  end

  // Datapath registers; out_data comes straight from a flop so c0..c2 never reach it combinationally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q      <= '0;
      out_data_q <= '0;
      for (int i = 0; i < VEC_LEN; i++) begin
        elem_q[i] <= '0;
      end
    end else begin
      idx_q      <= idx_d;
      out_data_q <= out_data_d;
      for (int i = 0; i < VEC_LEN; i++) begin
        elem_q[i] <= elem_d[i];
      end
    end
  end

  assign out_data = out_data_q;
  assign out_idx  = idx_q;

  // Accepted-vector counter, cleared together with the rest of the block
  matrix_vec_counter #(
    .W(8)
  ) u_vec_counter (
    .clk_i   (clk),
    .clr_n_i (rst_n),
    .en_i    (accept),
    .count_o (vec_count)
  );

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Self-checking bench for matrix_result_serializer.
// A table of per-cycle stimulus/expectation records covers the basic vector,
// backpressure and back-to-back streaming; hand-written sequences cover
// reset mid-vector, counter wrap and (when MATRIX_RESULT_ACC_EN is defined)
// accumulation.
module tb_matrix_result_serializer;

  localparam int DW = 16;

  logic          clk;
  logic          rstN;
  logic          inValid;
  logic          inReady;
  logic [DW-1:0] c0;
  logic [DW-1:0] c1;
  logic [DW-1:0] c2;
  logic          outValid;
  logic          outReady;
  logic [DW-1:0] outData;
  logic [1:0]    outIdx;
  logic          outLast;
  logic [7:0]    vecCount;
  logic          busy;
`ifdef MATRIX_RESULT_ACC_EN
  logic          accClr;
`endif

  int checks   = 0;
  int failures = 0;

  // One clock cycle of stimulus together with the outputs expected in that cycle
  typedef struct {
    logic          iv;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic          ordy;
    logic          eOv;
    logic [DW-1:0] eData;
    logic [1:0]    eIdx;
    logic          eLast;
    logic          eIr;
    logic          eBusy;
    logic [7:0]    eVc;
  } vec_t;

  vec_t tbl [23];

  matrix_result_serializer #(
    .DATA_W(DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .c0        (c0),
    .c1        (c1),
    .c2        (c2),
`ifdef MATRIX_RESULT_ACC_EN
    .acc_clr   (accClr),
`endif
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (outData),
    .out_idx   (outIdx),
    .out_last  (outLast),
    .vec_count (vecCount),
    .busy      (busy)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a stuck run still terminates with a visible failure
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison: counts it and reports on mismatch
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs just after the falling edge and let combinational outputs settle
  task automatic applyStimulus(input logic iv, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                               input logic [DW-1:0] d2, input logic ordy);
    @(negedge clk);
    inValid  = iv;
    c0       = d0;
    c1       = d1;
    c2       = d2;
    outReady = ordy;
    #1;
  endtask

  // Compare all observable outputs; data and index only matter while out_valid is high
  task automatic checkOutput(input string name, input logic eOv, input logic [DW-1:0] eData,
                             input logic [1:0] eIdx, input logic eLast, input logic eIr,
                             input logic eBusy, input logic [7:0] eVc);
    cmp({name, ".out_valid"}, 32'(outValid), 32'(eOv));
    if (eOv) begin
      cmp({name, ".out_data"}, 32'(outData), 32'(eData));
      cmp({name, ".out_idx"},  32'(outIdx),  32'(eIdx));
    end
    cmp({name, ".out_last"},  32'(outLast),  32'(eLast));
    cmp({name, ".in_ready"},  32'(inReady),  32'(eIr));
    cmp({name, ".busy"},      32'(busy),     32'(eBusy));
    cmp({name, ".vec_count"}, 32'(vecCount), 32'(eVc));
  endtask

  // Build one table record
  function automatic vec_t mk(input logic iv, input int d0, input int d1, input int d2,
                              input logic ordy, input logic eOv, input int eData,
                              input int eIdx, input logic eLast, input logic eIr,
                              input logic eBusy, input int eVc);
    vec_t v;
    v.iv    = iv;
    v.d0    = DW'(d0);
    v.d1    = DW'(d1);
    v.d2    = DW'(d2);
    v.ordy  = ordy;
    v.eOv   = eOv;
    v.eData = DW'(eData);
    v.eIdx  = 2'(eIdx);
    v.eLast = eLast;
    v.eIr   = eIr;
    v.eBusy = eBusy;
    v.eVc   = 8'(eVc);
    return v;
  endfunction

  // Hold reset for two edges and release it on a falling edge
  task automatic doReset();
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  // Main test sequence
  initial begin
    int wrapErr;
    rstN     = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    c0       = '0;
    c1       = '0;
    c2       = '0;
`ifdef MATRIX_RESULT_ACC_EN
    accClr   = 1'b1;
`endif

    // Table: basic vector, backpressure with junk on the inputs, back-to-back vectors
    tbl[0]  = mk(1, 100, 200, 300, 1,  0,   0, 0, 0, 1, 0, 0);
    tbl[1]  = mk(0,   0,   0,   0, 1,  1, 100, 0, 0, 0, 1, 1);
    tbl[2]  = mk(0,   0,   0,   0, 1,  1, 200, 1, 0, 0, 1, 1);
    tbl[3]  = mk(0,   0,   0,   0, 1,  1, 300, 2, 1, 1, 1, 1);
    tbl[4]  = mk(0,   0,   0,   0, 1,  0,   0, 0, 0, 1, 0, 1);
    tbl[5]  = mk(1, 111, 200, 333, 1,  0,   0, 0, 0, 1, 0, 1);
    tbl[6]  = mk(0,   0,   0,   0, 1,  1, 111, 0, 0, 0, 1, 2);
    tbl[7]  = mk(1,   9,   9,   9, 0,  1, 200, 1, 0, 0, 1, 2);
    tbl[8]  = mk(1,   9,   9,   9, 0,  1, 200, 1, 0, 0, 1, 2);
    tbl[9]  = mk(1,   9,   9,   9, 0,  1, 200, 1, 0, 0, 1, 2);
    tbl[10] = mk(1,   9,   9,   9, 0,  1, 200, 1, 0, 0, 1, 2);
    tbl[11] = mk(0,   0,   0,   0, 1,  1, 200, 1, 0, 0, 1, 2);
    tbl[12] = mk(1,   7,   7,   7, 0,  1, 333, 2, 1, 0, 1, 2);
    tbl[13] = mk(0,   0,   0,   0, 1,  1, 333, 2, 1, 1, 1, 2);
    tbl[14] = mk(0,   0,   0,   0, 1,  0,   0, 0, 0, 1, 0, 2);
    tbl[15] = mk(1,   1,   2,   3, 1,  0,   0, 0, 0, 1, 0, 2);
    tbl[16] = mk(1,   4,   5,   6, 1,  1,   1, 0, 0, 0, 1, 3);
    tbl[17] = mk(1,   4,   5,   6, 1,  1,   2, 1, 0, 0, 1, 3);
    tbl[18] = mk(1,   4,   5,   6, 1,  1,   3, 2, 1, 1, 1, 3);
    tbl[19] = mk(0,   0,   0,   0, 1,  1,   4, 0, 0, 0, 1, 4);
    tbl[20] = mk(0,   0,   0,   0, 1,  1,   5, 1, 0, 0, 1, 4);
    tbl[21] = mk(0,   0,   0,   0, 1,  1,   6, 2, 1, 1, 1, 4);
    tbl[22] = mk(0,   0,   0,   0, 1,  0,   0, 0, 0, 1, 0, 4);

    // Reset values while reset is held, then in the first cycle after release
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("in_reset", 0, 0, 0, 0, 1, 0, 0);
    cmp("in_reset.out_data", 32'(outData), 32'd0);
    cmp("in_reset.out_idx",  32'(outIdx),  32'd0);
    rstN = 1'b1;

    $display("[TB] running directed vector table");
    for (int i = 0; i < 23; i++) begin
      applyStimulus(tbl[i].iv, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].ordy);
      checkOutput($sformatf("row%0d", i), tbl[i].eOv, tbl[i].eData, tbl[i].eIdx,
                  tbl[i].eLast, tbl[i].eIr, tbl[i].eBusy, tbl[i].eVc);
    end

    // Reset mid-vector: element 0 seen, then reset; nothing more must come out
    $display("[TB] reset mid-vector");
    applyStimulus(1, 10, 20, 30, 1);
    checkOutput("mid.accept", 0, 0, 0, 0, 1, 0, 4);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("mid.elem0", 1, 10, 0, 0, 0, 1, 5);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checkOutput("mid.after_reset", 0, 0, 0, 0, 1, 0, 0);
    cmp("mid.after_reset.out_data", 32'(outData), 32'd0);
    cmp("mid.after_reset.out_idx",  32'(outIdx),  32'd0);
    applyStimulus(1, 40, 50, 60, 1);
    checkOutput("mid.new_accept", 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("mid.new_e0", 1, 40, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("mid.new_e1", 1, 50, 1, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("mid.new_e2", 1, 60, 2, 1, 1, 1, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("mid.idle", 0, 0, 0, 0, 1, 0, 1);

    // Wrap: 256 back-to-back vectors; accepts land every third cycle from cycle 0
    $display("[TB] vec_count wrap");
    doReset();
    wrapErr = 0;
    for (int k = 0; k < 766; k++) begin
      applyStimulus(1, 16'(k), 16'(k + 1), 16'(k + 2), 1);
      if (inReady !== ((k % 3) == 0)) wrapErr++;
      if (vecCount !== 8'((k + 2) / 3)) wrapErr++;
      if (k == 765) cmp("wrap.vec_count_255", 32'(vecCount), 32'd255);
    end
    cmp("wrap.pattern_errors", 32'(wrapErr), 32'd0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("wrap.after_256", 1, 16'd765, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("wrap.idle", 0, 0, 0, 0, 1, 0, 0);

`ifdef MATRIX_RESULT_ACC_EN
    // Accumulate: load (65535,1,2), idle a cycle, then add (1,1,1) with wrap on element 0
    $display("[TB] accumulate");
    doReset();
    accClr = 1'b1;
    applyStimulus(1, 65535, 1, 2, 1);
    checkOutput("acc.load", 0, 0, 0, 0, 1, 0, 0);
    accClr = 1'b0;
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("acc.l0", 1, 65535, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("acc.l1", 1, 1, 1, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("acc.l2", 1, 2, 2, 1, 1, 1, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("acc.idle", 0, 0, 0, 0, 1, 0, 1);
    applyStimulus(1, 1, 1, 1, 1);
    checkOutput("acc.add", 0, 0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("acc.s0", 1, 0, 0, 0, 0, 1, 2);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("acc.s1", 1, 2, 1, 0, 0, 1, 2);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("acc.s2", 1, 3, 2, 1, 1, 1, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
